// File: rtl/registers_scoreboard_if.sv
// Register file access bundle: N combinational read ports, one write port,
// one scoreboard claim port and the ready flag of the clear sequencer.
//   master : pipeline side (drives indices, write data, claims)
//   slave  : register file side (returns read data, busy bits, ready)
interface registers_scoreboard_if #(
  parameter int AddressBitWidth = 5,
  parameter int DataBitWidth    = 32,
  parameter int ReadPortCount   = 2
);
  logic                                     ready;
  logic [ReadPortCount*AddressBitWidth-1:0] rs;
  logic [ReadPortCount*DataBitWidth-1:0]    rs_dat;
  logic [ReadPortCount-1:0]                 rs_busy;
  logic [AddressBitWidth-1:0]               rd;
  logic                                     rd_we;
  logic [DataBitWidth-1:0]                  rd_wd;
  logic [AddressBitWidth-1:0]               claim;
  logic                                     claim_en;

  modport master (
    input  ready, rs_dat, rs_busy,
    output rs, rd, rd_we, rd_wd, claim, claim_en
  );

  modport slave (
    output ready, rs_dat, rs_busy,
    input  rs, rd, rd_we, rd_wd, claim, claim_en
  );
endinterface

// File: rtl/registers_scoreboard.sv
// Register file with pending-write scoreboard and post-reset clear sequencer.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset (restarts the clear sequence)
//   bus  : slave side of registers_scoreboard_if
//          ready            - clear finished, file usable
//          rs/rs_dat/rs_busy - ReadPortCount combinational read ports
//          rd/rd_we/rd_wd    - synchronous write port (clears pending)
//          claim/claim_en    - mark a register pending (sets pending)

// One read port: zero register, then same-cycle bypass, then storage.
module registers_scoreboard_rport #(
  parameter int AddressBitWidth = 5,
  parameter int DataBitWidth    = 32,
  parameter int ZeroRegister    = 1,
  parameter int BypassEnable    = 1,
  localparam int Depth          = 1 << AddressBitWidth
) (
  input  logic                                run,
  input  logic [AddressBitWidth-1:0]          idx,
  input  logic [Depth-1:0][DataBitWidth-1:0]  mem,
  input  logic [Depth-1:0]                    pending,
  input  logic [AddressBitWidth-1:0]          rd,
  input  logic                                rd_we,
  input  logic [DataBitWidth-1:0]             rd_wd,
  output logic [DataBitWidth-1:0]             dat,
  output logic                                busy
);
  always_comb begin
    dat  = '0;
    busy = 1'b0;
    if (!run) begin
      dat  = '0;
      busy = 1'b0;
    end else if (ZeroRegister != 0 && idx == '0) begin
      dat  = '0;
      busy = 1'b0;
    end else if (BypassEnable != 0 && rd_we && rd == idx) begin
      // the write in flight retires this register's hazard
      dat  = rd_wd;
      busy = 1'b0;
    end else begin
      dat  = mem[idx];
      busy = pending[idx];
    end
  end
endmodule

module registers_scoreboard #(
  parameter int AddressBitWidth = 5,
  parameter int DataBitWidth    = 32,
  parameter int ReadPortCount   = 2,
  parameter int ZeroRegister    = 1,
  parameter int BypassEnable    = 1
) (
  input logic                    clk,
  input logic                    rst,
  registers_scoreboard_if.slave  bus
);
  localparam int Depth = 1 << AddressBitWidth;
  localparam logic [AddressBitWidth:0] LastIdx = (AddressBitWidth+1)'(Depth - 1);
  localparam logic [AddressBitWidth:0] CntOne  = (AddressBitWidth+1)'(1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                               state, state_nxt;
  // one bit wider than the index so the terminal count never wraps
  logic [AddressBitWidth:0]             cnt, cnt_nxt;
  logic                                 clr_we;
  logic                                 run;
  logic                                 wr_ok, cl_ok;
  logic [Depth-1:0][DataBitWidth-1:0]   mem;
  logic [Depth-1:0]                     pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + CntOne;
        if (cnt == LastIdx) state_nxt = RUN;
      end
      RUN: ;
      default: state_nxt = CLEAR;
    endcase
  end

  assign run       = (state == RUN);
  assign bus.ready = run;

  assign wr_ok = run && bus.rd_we    && !(ZeroRegister != 0 && bus.rd == '0);
  assign cl_ok = run && bus.claim_en && !(ZeroRegister != 0 && bus.claim == '0);

  // storage has no reset: it is only zeroed by the sequencer
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we)     mem[cnt[AddressBitWidth-1:0]] <= '0;
      else if (wr_ok) mem[bus.rd] <= bus.rd_wd;
    end
  end

  // claim is applied last so a same-cycle claim of the written register wins
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (wr_ok) pending[bus.rd]    <= 1'b0;
      if (cl_ok) pending[bus.claim] <= 1'b1;
    end
  end

  genvar i;
  generate
    for (i = 0; i < ReadPortCount; i++) begin : g_rport
      registers_scoreboard_rport #(
        .AddressBitWidth (AddressBitWidth),
        .DataBitWidth    (DataBitWidth),
        .ZeroRegister    (ZeroRegister),
        .BypassEnable    (BypassEnable)
      ) u_rport (
        .run     (run),
        .idx     (bus.rs[i*AddressBitWidth +: AddressBitWidth]),
        .mem     (mem),
        .pending (pending),
        .rd      (bus.rd),
        .rd_we   (bus.rd_we),
        .rd_wd   (bus.rd_wd),
        .dat     (bus.rs_dat[i*DataBitWidth +: DataBitWidth]),
        .busy    (bus.rs_busy[i])
      );
    end
  endgenerate
endmodule

// File: doc/registers_scoreboard.md
Name: registers_scoreboard

Overview:
- Parametrised successor of the core register file.
- N asynchronous read ports and one synchronous write port.
- Optional same-cycle write-to-read bypass.
- Per-register pending-write scoreboard for hazard detection by the pipeline.
- Hardware clear sequencer that zeroes every entry after reset.

Parameters:
AddressBitWidth, 5, register index width; depth = 2**AddressBitWidth
DataBitWidth, 32, register data width
ReadPortCount, 2, number of independent read ports (>=1)
ZeroRegister, 1, 1 = index 0 hardwired to zero, never written, never pending
BypassEnable, 1, 1 = read ports see rd_wd in the same cycle it is written

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
ready  output  1  1 = clear sequence done, file usable
rs  input  ReadPortCount*AddressBitWidth  read indices; port i = slice i
rs_dat  output  ReadPortCount*DataBitWidth  read data; port i = slice i
rs_busy  output  ReadPortCount  1 = register on port i has a pending write
rd  input  AddressBitWidth  write index
rd_we  input  1  write enable
rd_wd  input  DataBitWidth  write data
claim  input  AddressBitWidth  register to mark pending (instruction issued)
claim_en  input  1  claim enable

Behaviour:
Reset:
- While rst=1 at a clock edge: ready<=0, clear counter<=0, all pending bits<=0.
- Storage is not touched during reset itself.
- Reset sampled mid-clear restarts the counter at 0.

Clear sequencer, states CLEAR -> RUN:
- CLEAR: each cycle mem[counter]<=0 and counter<=counter+1.
- After the last index (2**AddressBitWidth-1) is written, ready<=1 and the block enters RUN. ready therefore rises exactly 2**AddressBitWidth cycles after rst deasserts.
- In CLEAR: rd_we and claim_en are ignored, rs_dat=0, rs_busy=0.

RUN, write:
- rd_we=1 at an edge: mem[rd]<=rd_wd and pending[rd]<=0.
- When ZeroRegister=1 and rd=0: no effect.

RUN, claim:
- claim_en=1 at an edge: pending[claim]<=1.
- When ZeroRegister=1 and claim=0: ignored.
- Same register written and claimed in the same cycle: data is written and pending ends at 1 (claim wins).

RUN, read (combinational, zero latency, per port i):
- ZeroRegister=1 and rs[i]=0 -> rs_dat=0, rs_busy=0.
- Else, BypassEnable=1 and rd_we=1 and rd=rs[i] -> rs_dat=rd_wd, rs_busy=0.
- Else -> rs_dat=mem[rs[i]], rs_busy=pending[rs[i]].
- A same-cycle claim does not affect rs_busy until the next cycle.

Port independence: all read ports are independent; identical indices on several ports give identical results.

Width rules: no arithmetic on data. The counter is AddressBitWidth+1 bits so it can reach terminal count without wrap.

BypassEnable=0: reads return old contents during the write cycle, and rs_busy reflects the pending bit still set.

Test Plan:
- Reset sequencing: rst high 3 cycles, then low -> ready=0 for exactly 32 cycles, 1 from cycle 33. Writes issued during CLEAR to x5 are dropped: rs=5 reads 0 after ready.
- Basic write/read: write x7=0xDEADBEEF, x31=0x1 -> next cycle port0 rs=7 gives 0xDEADBEEF and port1 rs=31 gives 0x1, simultaneously.
- Zero register: rd=0, rd_wd=0xFFFFFFFF, rd_we=1, claim_en=1, claim=0 -> rs=0 gives 0, rs_busy=0 in the same cycle and after.
- Bypass: x3 holds 0x10; same cycle rd_we=1, rd=3, rd_wd=0x20 with rs=3 -> rs_dat=0x20, rs_busy=0. With BypassEnable=0 the same stimulus gives 0x10 that cycle and 0x20 the next.
- Scoreboard:
  - claim x9 -> rs_busy=1 next cycle.
  - Write x9=0x55 -> busy stays 1 in the write cycle only if BypassEnable=0; busy=0 afterwards.
  - Simultaneous claim+write of x9 -> data=0x55 and busy=1 after the edge.
- Reset mid-clear: assert rst at clear cycle 10 for 1 cycle, then release -> ready rises 32 cycles after the second release. Pending bits set before the reset read 0.
